// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit and keyboard receive paths:
// transmitter state encoding, common command bytes and frame construction.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        STOP,
        ACK,
        WAITIDLE
    } tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam int PS2_TX_FRAME_W = 10;

    // Host frame as shifted out LSB first: data, odd parity, stop.
    function automatic logic [PS2_TX_FRAME_W-1:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, plus a
// registered previous-clock flop used to flag falling clock edges.
module ps2_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_pin_i,
    input  logic dat_pin_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic fall_o
);

    logic [1:0] clk_meta_q;
    logic [1:0] dat_meta_q;
    logic       clk_prev_q;

    // Idle bus level is high, so resetting to 1 avoids a spurious edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_meta_q <= 2'b11;
            dat_meta_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep each flop sampling the
            // previous stage's old value, forming a real two-stage chain.
            clk_meta_q <= {clk_meta_q[0], clk_pin_i};
            dat_meta_q <= {dat_meta_q[0], dat_pin_i};
            clk_prev_q <= clk_meta_q[1];
        end
    end

    assign clk_sync_o = clk_meta_q[1];
    assign dat_sync_o = dat_meta_q[1];
    assign fall_o     = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low controls.
// Define PS2_TX_TIMEOUT_EN to add a watchdog from clock release to ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Data,
    input  logic       psClk,
    input  logic       psData,
    output logic       ClkLow,
    output logic       DatLow,
    output logic       Busy,
    output logic       TxActive,
    output logic       Done,
    output logic       Err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    tx_state_t                   state_q;
    logic [PS2_TX_FRAME_W-1:0]   shift_q;
    logic [3:0]                  bit_cnt_q;
    logic [INH_W-1:0]            inh_cnt_q;
    logic                        ack_q;
    logic                        clk_low_q;
    logic                        dat_low_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;

    logic                        clk_sync;
    logic                        dat_sync;
    logic                        clk_fall;
    logic                        to_hit;

    ps2_edge_sync u_sync (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .clk_pin_i  (psClk),
        .dat_pin_i  (psData),
        .clk_sync_o (clk_sync),
        .dat_sync_o (dat_sync),
        .fall_o     (clk_fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            wait_dev;

    assign wait_dev = (state_q == SEND) || (state_q == STOP) ||
                      (state_q == ACK)  || (state_q == WAITIDLE);

    // Cleared on the REQ->SEND transition, so SEND entry starts at zero.
    always_ff @(posedge Clk) begin
        if (Reset || state_q == REQ) begin
            to_cnt_q <= '0;
        end else if (wait_dev && !to_hit) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign to_hit = wait_dev && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            ack_q     <= 1'b0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (to_hit) begin
                clk_low_q <= 1'b0;
                dat_low_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                err_q     <= 1'b1;
                state_q   <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (Start) begin
                            shift_q   <= ps2_tx_frame(Data);
                            inh_cnt_q <= '0;
                            clk_low_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                            dat_low_q <= 1'b1;
                            state_q   <= REQ;
                        end else begin
                            inh_cnt_q <= inh_cnt_q + INH_W'(1);
                        end
                    end

                    // Releasing the clock with data held low is the request-to-send.
                    REQ: begin
                        clk_low_q <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= SEND;
                    end

                    SEND: begin
                        if (clk_fall) begin
                            dat_low_q <= ~shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd8) begin
                                state_q <= STOP;
                            end
                        end
                    end

                    STOP: begin
                        if (clk_fall) begin
                            dat_low_q <= 1'b0;
                            state_q   <= ACK;
                        end
                    end

                    ACK: begin
                        if (clk_fall) begin
                            ack_q   <= ~dat_sync;
                            state_q <= WAITIDLE;
                        end
                    end

                    WAITIDLE: begin
                        if (clk_sync && dat_sync) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= ~ack_q;
                            state_q <= IDLE;
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ClkLow   = clk_low_q;
    assign DatLow   = dat_low_q;
    assign Busy     = busy_q;
    assign TxActive = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device clocks frames out
// of the host while a monitor checks every Done pulse against queued expectations.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 3000;

    typedef struct {
        logic [7:0] data;
        logic       err;
        bit         chk_frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps_clk, ps_dat;
    logic       clk_low, dat_low, busy, tx_active, done, err;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sb_q[$];
    logic [10:0] dev_frame;
    int         inh_run = 0;
    logic       prev_done = 1'b0;

    always #5 clk = ~clk;

    // Wired-AND open-drain bus: either side may pull a line low.
    assign ps_clk = ~(clk_low | dev_clk_low);
    assign ps_dat = ~(dat_low | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .Start    (start),
        .Data     (data),
        .psClk    (ps_clk),
        .psData   (ps_dat),
        .ClkLow   (clk_low),
        .DatLow   (dat_low),
        .Busy     (busy),
        .TxActive (tx_active),
        .Done     (done),
        .Err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            f[b + 1] = d[b];
            ones += int'(d[b]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (done === 1'b1) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    check("txactive_at_done", {31'd0, tx_active}, 32'd0);
                    check("lines_at_done", {30'd0, clk_low, dat_low}, 32'd0);
                    if (e.chk_frame) begin
                        check("frame", {21'd0, dev_frame}, {21'd0, model_frame(e.data)});
                    end
                end
            end
            if (clk_low === 1'b1) begin
                inh_run++;
            end else if (inh_run > 0) begin
                check("inhibit_len", inh_run, INH + 1);
                inh_run = 0;
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [7:0] d, input logic exp_err, input bit chk);
        exp_t e;
        e.data = d;
        e.err = exp_err;
        e.chk_frame = chk;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
        check("start_busy", {30'd0, busy, tx_active}, 32'd3);
        check("start_clklow", {31'd0, clk_low}, 32'd1);
    endtask

    // Device side of one host-to-device frame. Returns early after abort_after
    // clock pulses; pulses Start with 0x00 during pulse spoil_at.
    task automatic device(input bit do_ack, input int half, input int abort_after, input int spoil_at);
        int budget;
        budget = 0;
        while (clk_low !== 1'b0 && budget < INH + 50) begin
            @(negedge clk);
            budget++;
        end
        check("clk_release", {31'd0, clk_low}, 32'd0);
        check("start_bit_held", {31'd0, dat_low}, 32'd1);
        dev_frame    = '0;
        dev_frame[0] = ps_dat;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_dat_low = do_ack;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == spoil_at) begin
                start = 1'b1;
                data  = 8'h00;
                @(negedge clk);
                start = 1'b0;
                repeat (half - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            if (i <= 10) dev_frame[i] = ps_dat;
            if (i == abort_after) return;
        end
        repeat (half) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check("done_seen", sb_q.size(), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input bit do_ack, input int spoil_at);
        issue(d, ~do_ack, 1'b1);
        device(do_ack, int'($urandom_range(30, 12)), 0, spoil_at);
        wait_done();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_clklow", {31'd0, clk_low}, 32'd0);
        check("rst_datlow", {31'd0, dat_low}, 32'd0);
        check("rst_busy", {30'd0, busy, tx_active}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        xfer(8'hED, 1'b1, 0);
        xfer(8'hFF, 1'b1, 0);
        xfer(8'hF4, 1'b0, 0);
        xfer(8'hED, 1'b1, 3);

        // Abort mid-frame: the expectation is withdrawn and no Done may follow.
        issue(8'($urandom), 1'b0, 1'b1);
        device(1'b1, 20, 4, 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_lines", {30'd0, clk_low, dat_low}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        xfer(8'hF4, 1'b1, 0);

        for (int k = 0; k < 6; k++) begin
            xfer(8'($urandom), 1'($urandom), 0);
        end

`ifdef PS2_TX_TIMEOUT_EN
        begin
            int n;
            issue(8'($urandom), 1'b1, 1'b0);
            n = 0;
            while (clk_low !== 1'b0 && n < INH + 50) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (done !== 1'b1 && n < TO + 100) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, TO);
            wait_done();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
